// File: rtl/bit_period_timer.sv
// Bit-period timing controller for the serial receive path: mid-bit sample strobes
// for each data bit, then a stop-bit interval ending in a one-cycle packet_done pulse.
module bit_period_timer #(
  parameter int CNT_BITS     = 16,
  parameter int BIT_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clear,
  input  logic [CNT_BITS-1:0]     bit_period,
  input  logic [BIT_CNT_BITS-1:0] num_bits,
  output logic                    shift_strobe,
  output logic                    packet_done,
  output logic                    busy,
  output logic [BIT_CNT_BITS-1:0] bit_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [CNT_BITS:0]       CNT_ONE = (CNT_BITS+1)'(1);
  localparam logic [BIT_CNT_BITS-1:0] BIT_ONE = BIT_CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0]     MIN_PER = CNT_BITS'(2);

  state_t                  state_reg, state_next;
  logic [CNT_BITS:0]       cnt_reg, cnt_next;
  logic [CNT_BITS-1:0]     period_reg, period_next;
  logic [BIT_CNT_BITS-1:0] nbits_reg, nbits_next;
  logic [BIT_CNT_BITS-1:0] bit_count_reg, bit_count_next;
  logic [BIT_CNT_BITS-1:0] bit_count_inc;
  logic [CNT_BITS:0]       first_target;
  logic [CNT_BITS:0]       target;
  logic                    hit;

  // The first interval lands mid-bit: 1.5 periods, one extra bit so P near max cannot wrap.
  assign first_target  = {1'b0, period_reg} + {2'b00, period_reg[CNT_BITS-1:1]};
  assign target        = (state_reg == FIRST) ? first_target : {1'b0, period_reg};
  assign hit           = (cnt_reg == target);
  assign bit_count_inc = bit_count_reg + BIT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      period_reg    <= '0;
      nbits_reg     <= '0;
      bit_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      period_reg    <= period_next;
      nbits_reg     <= nbits_next;
      bit_count_reg <= bit_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    period_next    = period_reg;
    nbits_next     = nbits_reg;
    bit_count_next = bit_count_reg;
    shift_strobe   = 1'b0;
    packet_done    = 1'b0;

    if (clear) begin
      // Abort: strobe/done of this cycle are dropped and bit_count keeps its value.
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next     = FIRST;
            cnt_next       = CNT_ONE;
            bit_count_next = '0;
            period_next    = (bit_period < MIN_PER) ? MIN_PER : bit_period;
            nbits_next     = (num_bits == '0) ? BIT_ONE : num_bits;
          end
        end
        FIRST, DATA: begin
          if (hit) begin
            shift_strobe   = 1'b1;
            cnt_next       = CNT_ONE;
            bit_count_next = bit_count_inc;
            state_next     = (bit_count_inc == nbits_reg) ? STOP : DATA;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        STOP: begin
          if (hit) begin
            packet_done = 1'b1;
            state_next  = IDLE;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign busy      = (state_reg != IDLE);
  assign bit_count = bit_count_reg;

endmodule

// File: tb/tb_bit_period_timer.sv
// Self-checking bench for bit_period_timer: every packet is compared cycle by cycle
// against expectations derived arithmetically from start cycle, P, N and any abort.
module tb_bit_period_timer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clear;
  logic [15:0] bit_period;
  logic [3:0]  num_bits;
  logic        shift_strobe;
  logic        packet_done;
  logic        busy;
  logic [3:0]  bit_count;

  int checks;
  int errors;
  int last_count;

  bit_period_timer #(.CNT_BITS(16), .BIT_CNT_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clear       (clear),
    .bit_period  (bit_period),
    .num_bits    (num_bits),
    .shift_strobe(shift_strobe),
    .packet_done (packet_done),
    .busy        (busy),
    .bit_count   (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string sig_name(input int i);
    case (i)
      0:       return "shift_strobe";
      1:       return "packet_done";
      2:       return "busy";
      default: return "bit_count";
    endcase
  endfunction

  // Strobes issued before cycle t of a packet started at cycle 0.
  function automatic int strobes_before(input int t, input int t1, input int p, input int n);
    int k;
    if (t <= t1) return 0;
    k = (t - 1 - t1) / p + 1;
    return (k > n) ? n : k;
  endfunction

  function automatic int model_done(input int per, input int nb);
    int p, n;
    p = (per < 2) ? 2 : per;
    n = (nb < 1) ? 1 : nb;
    return p + p / 2 + n * p;
  endfunction

  // Start at relative cycle 0; optional clear, re-start, input change and async reset cycles (-1 = none).
  task automatic run_packet(input string name, input int per, input int nb, input int clr_at,
                            input int rs_at, input int chg_at, input int rst_at);
    int p, n, t1, done_t, end_t;
    bit acc;
    int bad[4];
    int ft[4];
    int fg[4];
    int fw[4];
    int got[4];
    int want[4];
    int rst_bad;
    p      = (per < 2) ? 2 : per;
    n      = (nb < 1) ? 1 : nb;
    t1     = p + p / 2;
    done_t = t1 + n * p;
    acc    = (clr_at != 0);
    end_t  = done_t;
    if (clr_at >= 0 && clr_at < end_t) end_t = clr_at;
    if (rst_at >= 0 && rst_at < end_t) end_t = rst_at;
    rst_bad = 0;
    for (int i = 0; i < 4; i++) begin
      bad[i] = 0; ft[i] = 0; fg[i] = 0; fw[i] = 0;
    end
    for (int t = 0; t <= end_t; t++) begin
      @(negedge clk);
      start      = (t == 0) || (t == rs_at);
      clear      = (t == clr_at);
      bit_period = (chg_at >= 0 && t >= chg_at) ? 16'd100 : per[15:0];
      num_bits   = (chg_at >= 0 && t >= chg_at) ? 4'd7 : nb[3:0];
      #1;
      want[0] = (acc && t >= t1 && t <= t1 + (n - 1) * p && ((t - t1) % p) == 0 && t != clr_at) ? 1 : 0;
      want[1] = (acc && t == done_t && t != clr_at) ? 1 : 0;
      want[2] = (acc && t >= 1) ? 1 : 0;
      want[3] = (!acc || t == 0) ? last_count : strobes_before(t, t1, p, n);
      got[0]  = int'(shift_strobe);
      got[1]  = int'(packet_done);
      got[2]  = int'(busy);
      got[3]  = int'(bit_count);
      for (int i = 0; i < 4; i++) begin
        if (got[i] !== want[i]) begin
          if (bad[i] == 0) begin
            ft[i] = t; fg[i] = got[i]; fw[i] = want[i];
          end
          bad[i]++;
        end
      end
      if (t == rst_at) begin
        rst = 1'b1;
        #1;
        if ({shift_strobe, packet_done, busy, bit_count} !== 7'd0) rst_bad = 1;
        rst = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bad[i] != 0) begin
        errors++;
        $display("FAIL %s %s: %0d cycles differ, first at t=%0d got %0d want %0d",
                 name, sig_name(i), bad[i], ft[i], fg[i], fw[i]);
      end
    end
    if (rst_at >= 0) begin
      checks++;
      if (rst_bad != 0) begin
        errors++;
        $display("FAIL %s async_reset: outputs got nonzero want all zero at t=%0d", name, rst_at);
      end
    end
    if (rst_at >= 0 && rst_at <= end_t) last_count = 0;
    else if (!acc) last_count = last_count;
    else if (clr_at >= 0 && clr_at < done_t) last_count = strobes_before(clr_at, t1, p, n);
    else last_count = n;
    $display("packet %s P=%0d N=%0d cycles=%0d bit_count_expected=%0d", name, p, n, end_t + 1, last_count);
  endtask

  task automatic idle_check(input string name, input int cycles);
    int bad;
    int first_got;
    bad = 0;
    first_got = 0;
    for (int t = 0; t < cycles; t++) begin
      @(negedge clk);
      start = 1'b0;
      clear = 1'b0;
      #1;
      if ({shift_strobe, packet_done, busy} !== 3'b000 || int'(bit_count) != last_count) begin
        if (bad == 0) first_got = int'({shift_strobe, packet_done, busy, bit_count});
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s idle: %0d cycles differ, got {strobe,done,busy,count}=%0h want 0 and count %0d",
               name, bad, first_got, last_count);
    end
    $display("idle %s cycles=%0d", name, cycles);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; clear = 1'b0; bit_period = 16'd10; num_bits = 4'd8;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (shift_strobe !== 1'b0) begin errors++; $display("FAIL reset strobe got %b want 0", shift_strobe); end
    checks++;
    if (packet_done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", packet_done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++;
    if (bit_count !== 4'd0) begin errors++; $display("FAIL reset bit_count got %0d want 0", bit_count); end
    start = 1'b0;
    rst = 1'b0;
    last_count = 0;
    idle_check("after_reset", 3);
  endtask

  task automatic test_nominal();
    run_packet("nominal", 10, 8, -1, -1, -1, -1);
    idle_check("nominal_hold", 4);
  endtask

  task automatic test_minimum();
    run_packet("minimum", 0, 0, -1, -1, -1, -1);
    idle_check("minimum_hold", 2);
  endtask

  task automatic test_abort();
    run_packet("abort", 10, 8, 45, -1, -1, -1);
    idle_check("abort_idle", 4);
    run_packet("after_abort", 10, 8, 16, -1, -1, -1);
  endtask

  task automatic test_restart_ignored();
    run_packet("restart_ignored", 4, 2, -1, 7, 2, -1);
    idle_check("restart_hold", 3);
  endtask

  task automatic test_async_reset();
    run_packet("async_reset", 10, 8, -1, -1, -1, 20);
    idle_check("post_reset", 10);
    run_packet("post_reset_packet", 10, 2, -1, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    run_packet("b2b_max_bits", 3, 15, -1, -1, -1, -1);
    run_packet("b2b_second", 5, 4, -1, -1, -1, -1);
    idle_check("b2b_hold", 2);
  endtask

  task automatic test_clear_dominates();
    run_packet("clear_dominates", 6, 3, 0, -1, -1, -1);
    idle_check("clear_dominates_idle", 5);
  endtask

  task automatic test_random();
    int per, nb, dn, clr, rs;
    for (int k = 0; k < 12; k++) begin
      per = int'($urandom_range(0, 12));
      nb  = int'($urandom_range(0, 15));
      dn  = model_done(per, nb);
      clr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, dn - 1)) : -1;
      rs  = int'($urandom_range(1, (clr > 0) ? clr : dn));
      run_packet($sformatf("random%0d", k), per, nb, clr, rs, -1, -1);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("random%0d_gap", k), int'($urandom_range(1, 3)));
    end
  endtask

  // T1 = 65538 exceeds 16 bits; the strobe must land there, then abort to save time.
  task automatic test_wide_period();
    run_packet("wide_period", 43692, 1, 65540, -1, -1, -1);
    idle_check("wide_period_idle", 2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_count = 0;
    rst = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    bit_period = '0;
    num_bits = '0;
    test_reset();
    test_nominal();
    test_minimum();
    test_abort();
    test_restart_ignored();
    test_async_reset();
    test_back_to_back();
    test_clear_dominates();
    test_random();
    test_wide_period();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
